// File: rtl/fp_mul_share_ctrl.sv
// Shared single-precision multiplier front end: round-robin request arbitration,
// operand/result registering and a valid/ready response channel tagged with requester ID.

// Combinational single-precision multiply for normal operands with four rounding modes.
module fp_multiplier (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  rmode,
  output logic [31:0] result
);

  logic        sign;
  logic [47:0] prod;
  logic        norm;
  logic [23:0] keep;
  logic        guard;
  logic        sticky;
  logic        inexact;
  logic        inc;
  logic [24:0] rounded;
  logic [9:0]  exp_sum;
  logic        unused_bits;

  // Mantissa product, normalisation by at most one place, rounding and exponent sum
  always_comb begin
    sign = a[31] ^ b[31];
    prod = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    norm = prod[47];
    if (norm) begin
      keep   = prod[47:24];
      guard  = prod[23];
      sticky = |prod[22:0];
    end else begin
      keep   = prod[46:23];
      guard  = prod[22];
      sticky = |prod[21:0];
    end
    inexact = guard | sticky;
    case (rmode)
      2'b00:   inc = guard & (sticky | keep[0]);
      2'b01:   inc = 1'b0;
      2'b10:   inc = inexact & ~sign;
      default: inc = inexact & sign;
    endcase
    // A rounding carry out of the mantissa leaves the fraction zero and bumps the exponent
    rounded = {1'b0, keep} + 25'(inc);
    exp_sum = 10'(a[30:23]) + 10'(b[30:23]) - 10'd127 + 10'(norm) + 10'(rounded[24]);
    result  = {sign, exp_sum[7:0], rounded[22:0]};
  end

  assign unused_bits = ^{exp_sum[9:8], rounded[23]};

endmodule

module fp_mul_share_ctrl #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [32*NUM_REQ-1:0]  req_a,
  input  logic [32*NUM_REQ-1:0]  req_b,
  input  logic [2*NUM_REQ-1:0]   req_rmode,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [31:0]            rsp_result,
  output logic [ID_W-1:0]        rsp_id,
  output logic                   busy,
  output logic [15:0]            op_count
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned RM_W   = 2;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [DATA_W-1:0]   op_a_q, op_a_d;
  logic [DATA_W-1:0]   op_b_q, op_b_d;
  logic [RM_W-1:0]     op_rm_q, op_rm_d;
  logic [ID_W-1:0]     op_id_q, op_id_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_result_q, rsp_result_d;
  logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
  logic                busy_q, busy_d;
  logic [CNT_W-1:0]    op_count_q, op_count_d;

  logic                win_found;
  logic [ID_W-1:0]     win_id;
  logic [ID_W-1:0]     cand;
  logic [DATA_W-1:0]   mul_result;

  // Round-robin search starting just above the last accepted requester
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((32'(ptr_q) + k) % NUM_REQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  // Grant is combinational and only offered while idle and out of reset
  always_comb begin
    req_ready = '0;
    if (rst_n && (state_q == ST_IDLE) && win_found) begin
      req_ready[win_id] = 1'b1;
    end
  end

  fp_multiplier u_mul (
    .a      (op_a_q),
    .b      (op_b_q),
    .rmode  (op_rm_q),
    .result (mul_result)
  );

  // Next-state and next-register values
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_rm_d      = op_rm_q;
    op_id_d      = op_id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_id_d     = rsp_id_q;
    op_count_d   = op_count_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          op_a_d  = req_a[DATA_W*32'(win_id) +: DATA_W];
          op_b_d  = req_b[DATA_W*32'(win_id) +: DATA_W];
          op_rm_d = req_rmode[RM_W*32'(win_id) +: RM_W];
          op_id_d = win_id;
          ptr_d   = win_id;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_result_d = mul_result;
        rsp_id_d     = op_id_q;
        rsp_valid_d  = 1'b1;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          op_count_d  = op_count_q + 16'd1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ptr_q        <= ID_W'(NUM_REQ - 1);
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_rm_q      <= '0;
      op_id_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_id_q     <= '0;
      busy_q       <= 1'b0;
      op_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_rm_q      <= op_rm_d;
      op_id_q      <= op_id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_id_q     <= rsp_id_d;
      busy_q       <= busy_d;
      op_count_q   <= op_count_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_id     = rsp_id_q;
  assign busy       = busy_q;
  assign op_count   = op_count_q;

endmodule
